butterfly_p2s: RTL
==================

// Module: butterfly_p2s
// PURPOSE
//  Parallel-to-serial unroller: the stage directly downstream of butterfly_s2p's
//  counterpart path. Accepts one num_output-lane word per handshake and emits its lanes
//  one element per beat. The lane order applies the same bit-count rotation that
//  butterfly_s2p uses on write, so a p2s -> s2p round trip restores lane order.
// PARAMETERS
//  data_width  16  bits per element/lane
//  num_output  8   lanes per parallel word; power of two, >= 2
// PORTS
//  clk     in   1                      clock, all logic on rising edge
//  rst     in   1                      asynchronous, active-high reset
//  up_dat  in   num_output*data_width  parallel word; lane i = bits [i*W +: W]
//  up_vld  in   1                      upstream word valid
//  up_rdy  out  1                      block can accept a word this cycle
//  length  in   32                     frame length in elements, sampled at frame start
//  dn_dat  out  data_width             serial element
//  dn_vld  out  1                      dn_dat valid
//  dn_rdy  in   1                      downstream accepts element
// BEHAVIOUR
//  One clock; reset is asynchronous and active-high.
//  Reset values: hold register 0, dn_vld 0, dn_dat 0, up_rdy 1, lane_cnt 0, elem_cnt 0, state EMPTY.
//  Storage: one num_output*data_width hold register, a lane counter lane_cnt [log2(N)-1:0],
//   a frame element counter elem_cnt [31:0], and length_r [31:0].
//  States: EMPTY (no word held) / BUSY (word held, streaming).
//   EMPTY: up_rdy=1; up_vld -> load hold, state BUSY.
//   BUSY: dn_vld=1; each dn_vld&dn_rdy beat increments lane_cnt and elem_cnt.
//   Last lane (lane_cnt==N-1) accepted: if up_vld, reload hold and stay BUSY (no bubble);
//   else go EMPTY.
//  up_rdy = EMPTY | (BUSY & lane_cnt==N-1 & dn_rdy) -- combinational; no comb path up_vld->up_rdy.
//  Latency: word accepted at edge t -> first element on dn_dat after t (cycle t+1).
//  Throughput: 1 element/cycle sustained, N cycles per word.
//  Lane select: rot(c) = (c[L-1:0] + popcount(c[L+7:L])) mod N, L=log2(N), c=elem_cnt;
//   dn_dat = hold lane rot(elem_cnt), driven from registers via mux (no up_dat path).
//  Backpressure: dn_rdy=0 freezes lane_cnt, elem_cnt, hold; dn_dat/dn_vld stay stable.
//  Frame: length_r loads from length when a word is accepted with elem_cnt==0;
//   length changes mid-frame are ignored. On beat with elem_cnt==length_r-1,
//   elem_cnt wraps to 0 (rotation restarts). length_r==0: elem_cnt never wraps (free-run, mod 2^32).
//  length must be a multiple of N; otherwise elem_cnt wraps mid-word, lane_cnt is
//   unaffected (word still fully drained) and rotation follows elem_cnt.
//  Reset mid-word: hold content discarded, outputs to reset values next cycle.
// CONFIGURATION
//  BUTTERFLY_P2S_LAST_EN defined: adds output port dn_last (1 bit, reset 0), high with
//   dn_vld on the element where elem_cnt==length_r-1 (never when length_r==0).
//  Undefined: port absent, no extra logic; all other behaviour identical.
// TESTING (N=8, W=16)
//  length=16, word0 lane i=i, word1 lane i=0x10+i -> dn_dat 0..7, then 0x11..0x17,0x10.
//  length=16, third word lane i=0x20+i after wrap -> 0x20..0x27 (identity rotation again).
//  up_vld held 1, dn_rdy=1 -> dn_vld continuous 24 beats for 3 words; up_rdy=1 only on lane-7 beats.
//  dn_rdy=0 for 3 cycles at element 3 -> dn_dat=0x0003 held, no count advance, then 4..7.
//  rst=1 at element 5 -> next cycle dn_vld=0, up_rdy=1; new word restarts rotation at elem 0.
//  LAST_EN, length=16 -> dn_last=1 only on 16th beat; length=0 -> dn_last never asserted.
//  Round trip into butterfly_s2p with same length -> s2p output words equal p2s input words.

Source files
------------

// File: rtl/butterfly_p2s.sv
// ============================================================================
// butterfly_p2s : parallel-to-serial lane unroller with bit-count lane rotation
// Optional dn_last output when BUTTERFLY_P2S_LAST_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module butterfly_p2s #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_OUTPUT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_OUTPUT*DATA_WIDTH-1:0] up_dat,
  input  logic                             up_vld,
  output logic                             up_rdy,
  input  logic [31:0]                      length,
  output logic [DATA_WIDTH-1:0]            dn_dat,
  output logic                             dn_vld,
  input  logic                             dn_rdy
`ifdef BUTTERFLY_P2S_LAST_EN
  ,
  output logic                             dn_last
`endif
);

  localparam int L = $clog2(NUM_OUTPUT);
  localparam logic [L-1:0] LANE_ONE  = 1;
  localparam logic [L-1:0] LANE_LAST = '1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t                           state, state_nx;
  logic [NUM_OUTPUT*DATA_WIDTH-1:0] hold;
  logic [L-1:0]                     lane_cnt;
  logic [31:0]                      elem_cnt, elem_nx;
  logic [31:0]                      length_r;
  logic                             beat, accept, elem_wrap, last_lane;
  logic [3:0]                       pop;
  logic [L+3:0]                     rot_sum;
  logic [L-1:0]                     rot;
  logic [DATA_WIDTH-1:0]            lanes [NUM_OUTPUT];

  generate
    for (genvar g = 0; g < NUM_OUTPUT; g++) begin : g_lanes
      assign lanes[g] = hold[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign last_lane = (lane_cnt == LANE_LAST);
  assign beat      = (state == BUSY) && dn_rdy;
  assign up_rdy    = (state == EMPTY) || (last_lane && beat);
  assign accept    = up_vld && up_rdy;
  assign dn_vld    = (state == BUSY);
  // length_r == 0 means free-running: the counter only wraps at 2^32
  assign elem_wrap = (length_r != 32'd0) && (elem_cnt == length_r - 32'd1);
  assign elem_nx   = beat ? (elem_wrap ? 32'd0 : elem_cnt + 32'd1) : elem_cnt;

  // Rotation: low L bits of the element index plus popcount of the next 8 bits
  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) begin
      pop = pop + {3'b000, elem_cnt[L+i]};
    end
    rot_sum = {4'b0000, elem_cnt[L-1:0]} + {{L{1'b0}}, pop};
    rot     = rot_sum[L-1:0];
  end

  assign dn_dat = lanes[rot];

`ifdef BUTTERFLY_P2S_LAST_EN
  assign dn_last = (state == BUSY) && elem_wrap;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (up_vld) state_nx = BUSY;
      BUSY:    if (beat && last_lane && !up_vld) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      hold     <= '0;
      lane_cnt <= '0;
      elem_cnt <= '0;
      length_r <= '0;
    end else begin
      state    <= state_nx;
      elem_cnt <= elem_nx;
      if (beat) begin
        lane_cnt <= lane_cnt + LANE_ONE;
      end
      if (accept) begin
        hold <= up_dat;
      end
      // Frame starts on the word whose first element is index 0
      if (accept && (elem_nx == 32'd0)) begin
        length_r <= length;
      end
    end
  end

endmodule

`default_nettype wire
